// File: rtl/phy_idelay_tap_trainer_if.sv
// Control/status bundle between the IDELAY tap trainer and its surroundings
// (IDELAYCTRL, pattern checker, delay bank, MAC bring-up).
interface phy_idelay_tap_trainer_if;
    logic       idelayctrl_rdy_in;
    logic       train_start_in;
    logic       sample_valid_in;
    logic       sample_ok_in;
    logic [4:0] idelay_counter_value_in;
    logic       idelay_ld_out;
    logic       idelay_ce_out;
    logic       idelay_inc_out;
    logic       train_busy_out;
    logic       train_done_out;
    logic       train_fail_out;
    logic [4:0] eye_start_out;
    logic [5:0] eye_width_out;
    logic [4:0] tap_final_out;

    // Environment side: supplies readiness, start, checker results, CNTVALUE.
    modport master (
        output idelayctrl_rdy_in, train_start_in, sample_valid_in, sample_ok_in,
               idelay_counter_value_in,
        input  idelay_ld_out, idelay_ce_out, idelay_inc_out, train_busy_out,
               train_done_out, train_fail_out, eye_start_out, eye_width_out,
               tap_final_out
    );

    // Trainer side.
    modport slave (
        input  idelayctrl_rdy_in, train_start_in, sample_valid_in, sample_ok_in,
               idelay_counter_value_in,
        output idelay_ld_out, idelay_ce_out, idelay_inc_out, train_busy_out,
               train_done_out, train_fail_out, eye_start_out, eye_width_out,
               tap_final_out
    );
endinterface

// File: rtl/phy_idelay_tap_trainer.sv
// RGMII RX IDELAY tap trainer: loads the bank, walks it to tap 0, sweeps all
// 32 taps scoring each against the pattern checker, then centres the delay
// line in the longest passing window.
module phy_idelay_tap_trainer #(
    parameter int INIT_TAP      = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 64,
    parameter int MIN_EYE       = 4
) (
    input  logic                    idelay_clk_in,
    input  logic                    sys_rst,
    phy_idelay_tap_trainer_if.slave trn
);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_WAIT_RDY     = 4'd1;
    localparam logic [3:0] S_LOAD         = 4'd2;
    localparam logic [3:0] S_ZERO         = 4'd3;
    localparam logic [3:0] S_SETTLE       = 4'd4;
    localparam logic [3:0] S_SAMPLE       = 4'd5;
    localparam logic [3:0] S_EVAL         = 4'd6;
    localparam logic [3:0] S_CENTER       = 4'd7;
    localparam logic [3:0] S_SETTLE_FINAL = 4'd8;
    localparam logic [3:0] S_DONE         = 4'd9;
    localparam logic [3:0] S_FAIL         = 4'd10;

    logic [3:0]       state, state_nxt;
    logic [4:0]       tap;
    logic [CNT_W-1:0] cnt;
    logic             all_ok;
    logic [5:0]       run_len, best_len, cand_len;
    logic [4:0]       run_start, best_start, cand_start;
    logic [5:0]       target;
    logic             ld_r, ce_r, inc_r;
    logic [4:0]       eye_start_r, tap_final_r;
    logic [5:0]       eye_width_r;

    logic start_acc, rdy_lost, settle_last, sample_last, tap_pass, run_close;
    logic cnt_match;

    assign start_acc   = trn.train_start_in &&
                         (state == S_IDLE || state == S_DONE || state == S_FAIL);
    // Losing IDELAYCTRL ready only matters once the bank is being driven.
    assign rdy_lost    = !trn.idelayctrl_rdy_in &&
                         (state >= S_LOAD && state <= S_SETTLE_FINAL);
    assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign sample_last = (state == S_SAMPLE) && trn.sample_valid_in &&
                         (cnt == CNT_W'(SAMPLES - 1));
    assign tap_pass    = all_ok && trn.sample_ok_in;
    assign cnt_match   = (trn.idelay_counter_value_in == tap);

    // Run bookkeeping for the tap being closed out by its last strobe.
    always_comb begin
        cand_len   = tap_pass ? run_len + 6'd1 : run_len;
        cand_start = (tap_pass && run_len == 6'd0) ? tap : run_start;
        run_close  = !tap_pass || (tap == 5'd31);
    end

    // Next-state decode; a ready drop overrides everything while busy.
    always_comb begin
        state_nxt = state;
        if (rdy_lost) begin
            state_nxt = S_FAIL;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: if (trn.train_start_in) state_nxt = S_WAIT_RDY;
                S_WAIT_RDY:     if (trn.idelayctrl_rdy_in) state_nxt = S_LOAD;
                S_LOAD:         state_nxt = S_ZERO;
                S_ZERO:         if (tap == 5'd0) state_nxt = S_SETTLE;
                S_SETTLE:       if (settle_last) state_nxt = cnt_match ? S_SAMPLE : S_FAIL;
                S_SAMPLE:       if (sample_last) state_nxt = (tap == 5'd31) ? S_EVAL : S_SETTLE;
                S_EVAL:         state_nxt = (best_len < 6'(MIN_EYE)) ? S_FAIL : S_CENTER;
                S_CENTER:       if ({1'b0, tap} == target) state_nxt = S_SETTLE_FINAL;
                S_SETTLE_FINAL: if (settle_last) state_nxt = cnt_match ? S_DONE : S_FAIL;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge idelay_clk_in or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Tap tracking, delay-bank strobes, settle/sample counting, run scoring.
    // CE is forced low every cycle unless a pulse is issued, so pulses are one
    // cycle wide and the ce_r check in ZERO/CENTER leaves a gap between them.
    always_ff @(posedge idelay_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            tap        <= '0;
            cnt        <= '0;
            all_ok     <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            target     <= '0;
            ld_r       <= 1'b0;
            ce_r       <= 1'b0;
            inc_r      <= 1'b0;
        end else begin
            ld_r <= 1'b0;
            ce_r <= 1'b0;
            if (!rdy_lost) begin
                case (state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (trn.train_start_in) begin
                            cnt        <= '0;
                            run_len    <= '0;
                            run_start  <= '0;
                            best_len   <= '0;
                            best_start <= '0;
                        end
                    end
                    S_LOAD: begin
                        ld_r <= 1'b1;
                        tap  <= 5'(INIT_TAP);
                    end
                    S_ZERO: begin
                        if (tap != 5'd0 && !ce_r) begin
                            ce_r  <= 1'b1;
                            inc_r <= 1'b0;
                            tap   <= tap - 5'd1;
                        end
                    end
                    S_SETTLE, S_SETTLE_FINAL: begin
                        cnt    <= settle_last ? '0 : cnt + CNT_W'(1);
                        all_ok <= 1'b1;
                    end
                    S_SAMPLE: begin
                        if (trn.sample_valid_in) begin
                            all_ok <= tap_pass;
                            if (sample_last) begin
                                cnt <= '0;
                                if (run_close) begin
                                    run_len <= '0;
                                    if (cand_len > best_len) begin
                                        best_len   <= cand_len;
                                        best_start <= cand_start;
                                    end
                                end else begin
                                    run_len <= cand_len;
                                end
                                run_start <= cand_start;
                                if (tap != 5'd31) begin
                                    ce_r  <= 1'b1;
                                    inc_r <= 1'b1;
                                    tap   <= tap + 5'd1;
                                end
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_EVAL: begin
                        // start + width/2 stays within 0..31 because start+width <= 32.
                        target <= {1'b0, best_start} + (best_len >> 1);
                    end
                    S_CENTER: begin
                        if ({1'b0, tap} != target && !ce_r) begin
                            ce_r  <= 1'b1;
                            inc_r <= 1'b0;
                            tap   <= tap - 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Result registers: cleared on start, captured on the way into EVAL's
    // centring, DONE or FAIL.
    always_ff @(posedge idelay_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            eye_start_r <= '0;
            eye_width_r <= '0;
            tap_final_r <= '0;
        end else if (start_acc) begin
            eye_start_r <= '0;
            eye_width_r <= '0;
            tap_final_r <= '0;
        end else if (state_nxt == S_FAIL && state != S_FAIL) begin
            eye_start_r <= best_start;
            eye_width_r <= best_len;
            tap_final_r <= tap;
        end else if (state == S_EVAL && state_nxt == S_CENTER) begin
            eye_start_r <= best_start;
            eye_width_r <= best_len;
        end else if (state_nxt == S_DONE && state != S_DONE) begin
            tap_final_r <= tap;
        end
    end

    assign trn.idelay_ld_out  = ld_r;
    assign trn.idelay_ce_out  = ce_r;
    assign trn.idelay_inc_out = inc_r;
    assign trn.train_busy_out = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign trn.train_done_out = (state == S_DONE);
    assign trn.train_fail_out = (state == S_FAIL);
    assign trn.eye_start_out  = eye_start_r;
    assign trn.eye_width_out  = eye_width_r;
    assign trn.tap_final_out  = tap_final_r;
endmodule

// File: tb/tb_phy_idelay_tap_trainer.sv
// Directed bench for phy_idelay_tap_trainer: models the IDELAY bank counter
// and a pass/fail-mask pattern checker, then runs training scenarios.
`timescale 1ns/1ps
module tb_phy_idelay_tap_trainer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phy_idelay_tap_trainer_if trn();

    phy_idelay_tap_trainer #(
        .INIT_TAP(10), .SETTLE_CYCLES(16), .SAMPLES(64), .MIN_EYE(4)
    ) dut (
        .idelay_clk_in(clk),
        .sys_rst      (rst),
        .trn          (trn)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mask    = 32'hFFFF_FFFF;
    int          bad_tap = -1;
    logic        stuck   = 1'b0;

    // Delay bank model plus strobe counters.
    logic [4:0] dl_val;
    logic       ce_q = 1'b0;
    int n_inc = 0, n_dec = 0, n_ld = 0, n_back = 0;
    always @(posedge clk) begin
        if (trn.idelay_ld_out) dl_val <= 5'd10;
        else if (trn.idelay_ce_out) dl_val <= trn.idelay_inc_out ? dl_val + 5'd1 : dl_val - 5'd1;
        if (trn.idelay_ce_out && trn.idelay_inc_out)  n_inc  <= n_inc + 1;
        if (trn.idelay_ce_out && !trn.idelay_inc_out) n_dec  <= n_dec + 1;
        if (trn.idelay_ld_out)                        n_ld   <= n_ld + 1;
        if (trn.idelay_ce_out && ce_q)                n_back <= n_back + 1;
        ce_q <= trn.idelay_ce_out;
    end
    assign trn.idelay_counter_value_in = stuck ? 5'd0 : dl_val;

    // Pattern checker: strobes 3 of every 4 cycles, result from the tap mask,
    // with an optional single bad strobe (the 31st seen at bad_tap).
    int cyc = 0, scnt = 0;
    logic [4:0] last_val;
    always @(negedge clk) begin
        if (dl_val !== last_val) scnt = 0;
        last_val = dl_val;
        trn.sample_valid_in = (cyc % 4) != 3;
        trn.sample_ok_in = mask[dl_val] && !(int'(dl_val) == bad_tap && scnt == 30);
        if (trn.sample_valid_in) scnt++;
        cyc++;
    end

    task automatic pulse_start();
        @(negedge clk); trn.train_start_in = 1'b1;
        @(negedge clk); trn.train_start_in = 1'b0;
    endtask

    task automatic wait_end(output bit to);
        to = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (trn.train_done_out || trn.train_fail_out) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({trn.idelay_ld_out, trn.idelay_ce_out, trn.idelay_inc_out} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {trn.idelay_ld_out, trn.idelay_ce_out, trn.idelay_inc_out}); end
        checks++; if ({trn.train_busy_out, trn.train_done_out, trn.train_fail_out} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {trn.train_busy_out, trn.train_done_out, trn.train_fail_out}); end
        checks++; if ({trn.eye_start_out, trn.eye_width_out, trn.tap_final_out} !== 16'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", {trn.eye_start_out, trn.eye_width_out, trn.tap_final_out}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_pass();
        bit to;
        int b_inc = n_inc, b_dec = n_dec, b_ld = n_ld, b_back = n_back;
        mask = 32'hFFFF_FFFF; bad_tap = -1;
        pulse_start();
        checks++; if (trn.train_busy_out !== 1'b1) begin errors++; $display("FAIL all_busy: got %b expected 1", trn.train_busy_out); end
        wait_end(to);
        checks++; if (to) begin errors++; $display("FAIL all_timeout: got timeout expected completion"); end
        checks++; if (trn.train_done_out !== 1'b1 || trn.train_fail_out !== 1'b0) begin errors++; $display("FAIL all_done: got done=%b fail=%b expected 1/0", trn.train_done_out, trn.train_fail_out); end
        checks++; if (trn.eye_start_out !== 5'd0) begin errors++; $display("FAIL all_start: got %0d expected 0", trn.eye_start_out); end
        checks++; if (trn.eye_width_out !== 6'd32) begin errors++; $display("FAIL all_width: got %0d expected 32", trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd16) begin errors++; $display("FAIL all_tap: got %0d expected 16", trn.tap_final_out); end
        checks++; if (n_inc - b_inc != 31) begin errors++; $display("FAIL all_incs: got %0d expected 31", n_inc - b_inc); end
        checks++; if (n_dec - b_dec != 25) begin errors++; $display("FAIL all_decs: got %0d expected 25", n_dec - b_dec); end
        checks++; if (n_ld - b_ld != 1) begin errors++; $display("FAIL all_ld: got %0d expected 1", n_ld - b_ld); end
        checks++; if (n_back != b_back) begin errors++; $display("FAIL all_ce_gap: got %0d adjacent CE cycles expected 0", n_back - b_back); end
        checks++; if (dl_val !== 5'd16) begin errors++; $display("FAIL all_cntvalue: got %0d expected 16", dl_val); end
        checks++; if (trn.train_busy_out !== 1'b0) begin errors++; $display("FAIL all_idle: got busy=%b expected 0", trn.train_busy_out); end
    endtask

    task automatic test_window();
        bit to;
        mask = 32'h000F_FF00; bad_tap = -1;
        pulse_start(); wait_end(to);
        checks++; if (to || trn.train_done_out !== 1'b1) begin errors++; $display("FAIL win_done: got done=%b timeout=%0d expected 1/0", trn.train_done_out, to); end
        checks++; if (trn.eye_start_out !== 5'd8) begin errors++; $display("FAIL win_start: got %0d expected 8", trn.eye_start_out); end
        checks++; if (trn.eye_width_out !== 6'd12) begin errors++; $display("FAIL win_width: got %0d expected 12", trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd14) begin errors++; $display("FAIL win_tap: got %0d expected 14", trn.tap_final_out); end
        checks++; if (dl_val !== 5'd14) begin errors++; $display("FAIL win_cntvalue: got %0d expected 14", dl_val); end
    endtask

    task automatic test_tie();
        bit to;
        mask = 32'h01F0_00F8; bad_tap = -1;
        pulse_start(); wait_end(to);
        checks++; if (to || trn.train_done_out !== 1'b1) begin errors++; $display("FAIL tie_done: got done=%b timeout=%0d expected 1/0", trn.train_done_out, to); end
        checks++; if (trn.eye_start_out !== 5'd3 || trn.eye_width_out !== 6'd5) begin errors++; $display("FAIL tie_eye: got start=%0d width=%0d expected 3/5", trn.eye_start_out, trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd5) begin errors++; $display("FAIL tie_tap: got %0d expected 5", trn.tap_final_out); end
        mask = 32'hFE00_0078;
        pulse_start(); wait_end(to);
        checks++; if (to || trn.train_done_out !== 1'b1) begin errors++; $display("FAIL edge31_done: got done=%b timeout=%0d expected 1/0", trn.train_done_out, to); end
        checks++; if (trn.eye_start_out !== 5'd25 || trn.eye_width_out !== 6'd7) begin errors++; $display("FAIL edge31_eye: got start=%0d width=%0d expected 25/7", trn.eye_start_out, trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd28) begin errors++; $display("FAIL edge31_tap: got %0d expected 28", trn.tap_final_out); end
    endtask

    task automatic test_narrow();
        bit to;
        mask = 32'h0000_1C00; bad_tap = -1;
        pulse_start(); wait_end(to);
        checks++; if (to || trn.train_fail_out !== 1'b1 || trn.train_done_out !== 1'b0) begin errors++; $display("FAIL narrow_status: got fail=%b done=%b expected 1/0", trn.train_fail_out, trn.train_done_out); end
        checks++; if (trn.eye_start_out !== 5'd10 || trn.eye_width_out !== 6'd3) begin errors++; $display("FAIL narrow_eye: got start=%0d width=%0d expected 10/3", trn.eye_start_out, trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd31) begin errors++; $display("FAIL narrow_tap: got %0d expected 31", trn.tap_final_out); end
        checks++; if (trn.train_busy_out !== 1'b0) begin errors++; $display("FAIL narrow_busy: got %b expected 0", trn.train_busy_out); end
    endtask

    task automatic test_glitch();
        bit to;
        mask = 32'h0000_FFE0; bad_tap = 9;
        pulse_start(); wait_end(to);
        bad_tap = -1;
        checks++; if (to || trn.train_done_out !== 1'b1) begin errors++; $display("FAIL glitch_done: got done=%b timeout=%0d expected 1/0", trn.train_done_out, to); end
        checks++; if (trn.eye_start_out !== 5'd10 || trn.eye_width_out !== 6'd6) begin errors++; $display("FAIL glitch_eye: got start=%0d width=%0d expected 10/6", trn.eye_start_out, trn.eye_width_out); end
        checks++; if (trn.tap_final_out !== 5'd13) begin errors++; $display("FAIL glitch_tap: got %0d expected 13", trn.tap_final_out); end
    endtask

    task automatic test_rdy_drop();
        bit reached = 1'b0;
        int b_inc = n_inc, ce_tot, ld_b;
        mask = 32'hFFFF_FFFF;
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (n_inc - b_inc == 17) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin errors++; $display("FAIL rdy_reach17: got timeout expected tap 17"); end
        repeat (30) @(negedge clk);
        trn.idelayctrl_rdy_in = 1'b0;
        @(negedge clk);
        checks++; if (trn.train_fail_out !== 1'b1 || trn.train_busy_out !== 1'b0) begin errors++; $display("FAIL rdy_fail: got fail=%b busy=%b expected 1/0", trn.train_fail_out, trn.train_busy_out); end
        checks++; if (trn.tap_final_out !== 5'd17) begin errors++; $display("FAIL rdy_tap: got %0d expected 17", trn.tap_final_out); end
        ce_tot = n_inc + n_dec; ld_b = n_ld;
        repeat (40) @(negedge clk);
        checks++; if (n_inc + n_dec != ce_tot || n_ld != ld_b) begin errors++; $display("FAIL rdy_no_ce: got %0d extra strobes expected 0", n_inc + n_dec + n_ld - ce_tot - ld_b); end
        trn.idelayctrl_rdy_in = 1'b1;
    endtask

    task automatic test_stuck();
        bit to;
        int b_inc = n_inc;
        mask = 32'hFFFF_FFFF; stuck = 1'b1;
        pulse_start(); wait_end(to);
        checks++; if (to || trn.train_fail_out !== 1'b1) begin errors++; $display("FAIL stuck_fail: got fail=%b timeout=%0d expected 1/0", trn.train_fail_out, to); end
        checks++; if (trn.tap_final_out !== 5'd1 || trn.eye_width_out !== 6'd0) begin errors++; $display("FAIL stuck_result: got tap=%0d width=%0d expected 1/0", trn.tap_final_out, trn.eye_width_out); end
        checks++; if (n_inc - b_inc != 1) begin errors++; $display("FAIL stuck_incs: got %0d expected 1", n_inc - b_inc); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        mask = 32'hFFFF_FFFF;
        pulse_start();
        repeat (300) @(negedge clk);
        checks++; if (trn.train_busy_out !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", trn.train_busy_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({trn.idelay_ld_out, trn.idelay_ce_out, trn.idelay_inc_out, trn.train_busy_out,
                       trn.train_done_out, trn.train_fail_out, trn.eye_start_out, trn.eye_width_out,
                       trn.tap_final_out} !== 22'd0) begin
            errors++; $display("FAIL rstmid_outputs: got nonzero outputs expected all 0");
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        bit to;
        int b_ld = n_ld;
        mask = 32'h000F_FF00;
        pulse_start();
        repeat (500) @(negedge clk);
        pulse_start();
        wait_end(to);
        checks++; if (to || trn.train_done_out !== 1'b1) begin errors++; $display("FAIL ign_done: got done=%b timeout=%0d expected 1/0", trn.train_done_out, to); end
        checks++; if (n_ld - b_ld != 1) begin errors++; $display("FAIL ign_ld: got %0d expected 1", n_ld - b_ld); end
        checks++; if (trn.tap_final_out !== 5'd14) begin errors++; $display("FAIL ign_tap: got %0d expected 14", trn.tap_final_out); end
    endtask

    initial begin
        trn.idelayctrl_rdy_in = 1'b1;
        trn.train_start_in    = 1'b0;
        test_reset();
        test_all_pass();
        test_window();
        test_tie();
        test_narrow();
        test_glitch();
        test_rdy_drop();
        test_stuck();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/phy_idelay_tap_trainer.md
Name: phy_idelay_tap_trainer

Overview:
- Sequences the RGMII RX IDELAYE2 bank (VARIABLE mode, 32 taps) through a full tap sweep and records pass/fail per tap from an external pattern checker.
- Finds the longest contiguous passing window, moves the delay line to its centre, then reports the result.
- Drives the shared LD/CE/INC controls of the IDELAY bank and sits between the RGMII RX front end and the MAC bring-up logic.

Parameters:
INIT_TAP, 10, tap loaded by LD (must equal IDELAY_VALUE of the delay bank), 0..31
SETTLE_CYCLES, 16, idle cycles after any tap change before sampling, >=1
SAMPLES, 64, checker samples evaluated per tap, >=1
MIN_EYE, 4, minimum passing-window width for success, 1..32

Ports:
idelay_clk_in  input  1  IDELAY control clock; all logic on rising edge
sys_rst  input  1  asynchronous active-high reset
idelayctrl_rdy_in  input  1  IDELAYCTRL ready
train_start_in  input  1  single-cycle start request
sample_valid_in  input  1  checker result strobe
sample_ok_in  input  1  checker result, qualified by sample_valid_in
idelay_counter_value_in  input  5  CNTVALUEOUT of lane 0
idelay_ld_out  output  1  LD to delay bank
idelay_ce_out  output  1  CE to delay bank
idelay_inc_out  output  1  INC to delay bank
train_busy_out  output  1  training in progress
train_done_out  output  1  training finished with a valid eye (level)
train_fail_out  output  1  training failed (level)
eye_start_out  output  5  first tap of the chosen window
eye_width_out  output  6  width of the chosen window, 0..32
tap_final_out  output  5  tap applied at completion

Behaviour:
- Reset: all outputs 0; state IDLE; internal tap register = 0.
- IDLE: train_start_in=1 -> WAIT_RDY; clears done, fail, eye_start, eye_width, tap_final. train_start_in outside IDLE/DONE/FAIL is ignored. DONE and FAIL also accept train_start_in (retrain).
- train_busy_out = 1 in every state except IDLE, DONE, FAIL.
- WAIT_RDY: hold until idelayctrl_rdy_in=1 -> LOAD.
- LOAD: idelay_ld_out=1 for exactly one cycle; tap := INIT_TAP -> ZERO.
- ZERO: while tap != 0, issue a decrement (ce=1, inc=0 for one cycle, then one cycle with ce=0); tap := tap-1 on each pulse. At tap=0 -> SETTLE.
- CE pulses are always exactly one cycle, with at least one ce=0 cycle between pulses. idelay_inc_out is valid in every cycle where ce=1.
- SETTLE: count SETTLE_CYCLES cycles. Then compare idelay_counter_value_in with tap; mismatch -> FAIL; match -> SAMPLE.
- SAMPLE: count sample_valid_in strobes up to SAMPLES. The tap passes only if every strobe carries sample_ok_in=1. Strobes seen in other states are discarded.
- After SAMPLES strobes, update run tracking:
  - pass: run_len := run_len+1; run_start := tap when run_len was 0.
  - fail: close the run.
  - A run is closed on the first failing tap or after tap 31. It replaces the best run only if strictly longer, so ties keep the lowest-starting run.
  - Then tap<31 -> one increment pulse, tap+1 -> SETTLE; tap=31 -> EVAL.
- EVAL:
  - best_width < MIN_EYE -> FAIL.
  - Otherwise target := best_start + (best_width>>1), computed in 6-bit arithmetic, always <=31; -> CENTER.
- CENTER: decrement pulses from 31 to target (none if target=31) -> SETTLE_FINAL (SETTLE_CYCLES + counter check, mismatch -> FAIL) -> DONE.
- DONE: train_done_out=1; eye_start_out/eye_width_out/tap_final_out hold their values until the next start or reset.
- FAIL: train_fail_out=1; eye_start_out/eye_width_out carry the best run found so far (width may be 0); tap_final_out = current tap; delay line is left as is.
- idelayctrl_rdy_in falling in any busy state after WAIT_RDY -> FAIL next cycle; no further CE/LD pulses are issued.
- Asynchronous reset mid-training: outputs go to 0 immediately; the delay line is not restored (the next training reloads it via LD).
- Tap never wraps: the controller never increments at 31 or decrements at 0.

Test Plan:
1. All taps pass (ok=1 always), MIN_EYE=4 -> 10 decrements, 31 increments, then 15 decrements; eye_start=0, eye_width=32, tap_final=16, done=1.
2. Taps 8..19 pass, others fail -> eye_start=8, eye_width=12, tap_final=14, done=1; CNTVALUE model reads 14.
3. Two windows, 3..7 and 20..24 (both width 5) -> tie keeps eye_start=3, tap_final=5. Second variant: windows 3..6 and 25..31 -> eye_start=25, eye_width=7, tap_final=28 (run closed at tap 31).
4. Only taps 10..12 pass, MIN_EYE=4 -> fail=1, done=0, eye_width=3, eye_start=10, tap_final=31, busy=0.
5. A single ok=0 strobe among 64 at tap 9 within a 5..15 window -> windows 5..8 and 10..15; eye_start=10, eye_width=6, tap_final=13.
6. Edge cases:
   - idelayctrl_rdy_in deasserted mid-sweep at tap 17 -> fail=1 next cycle, no further CE.
   - CNTVALUE model stuck at 0 -> fail after the first increment's SETTLE.
   - sys_rst asserted mid-sweep -> all outputs 0 asynchronously.
   - train_start_in pulsed while busy -> ignored.
